// File: rtl/razor_pkg.sv
// Shared types and constants for the razor pipeline writeback path.
package razor_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_NONE = 2'd3
  } wb_src_e;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a load word and sign- or zero-extends it.
module load_align
  import razor_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_rdata >> {i_addr_lo, 3'b000});
  assign w_half = 16'(i_rdata >> {i_addr_lo[1], 4'b0000});

  always_comb begin
    o_value = i_rdata;
    case (i_funct3)
      F3_LB:   o_value = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_value = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_value = {24'd0, w_byte};
      F3_LHU:  o_value = {16'd0, w_half};
      default: o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring instructions, waits for load data, drives the register-file write port.
module wb_stage
  import razor_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wb_src,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [31:0]      in_alu,
  input  logic [31:0]      in_pc4,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             load_pending,
  output logic [4:0]       load_rd,
  output logic             bus_err,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned TO_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  wb_state_e        r_state, w_state_nxt;
  logic [TO_W-1:0]  r_to_cnt, w_to_cnt_nxt;
  logic [4:0]       r_ld_rd, w_ld_rd_nxt;
  logic [2:0]       r_ld_f3, w_ld_f3_nxt;
  logic [1:0]       r_ld_lo, w_ld_lo_nxt;
  logic             r_wb_we, w_wb_we_nxt;
  logic [4:0]       r_wb_rd, w_wb_rd_nxt;
  logic [31:0]      r_wb_data, w_wb_data_nxt;
  logic             r_bus_err, w_bus_err_nxt;
  logic [CNT_W-1:0] r_retire, w_retire_nxt;
  logic [31:0]      w_load_val;
  wb_src_e          w_src;

  load_align u_load_align (
    .i_funct3  (r_ld_f3),
    .i_addr_lo (r_ld_lo),
    .i_rdata   (dmem_rdata),
    .o_value   (w_load_val)
  );

  assign w_src = wb_src_e'(in_wb_src);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_to_cnt  <= '0;
      r_ld_rd   <= '0;
      r_ld_f3   <= '0;
      r_ld_lo   <= '0;
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_bus_err <= 1'b0;
      r_retire  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_ld_rd   <= w_ld_rd_nxt;
      r_ld_f3   <= w_ld_f3_nxt;
      r_ld_lo   <= w_ld_lo_nxt;
      r_wb_we   <= w_wb_we_nxt;
      r_wb_rd   <= w_wb_rd_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_bus_err <= w_bus_err_nxt;
      r_retire  <= w_retire_nxt;
    end
  end

  // wb_rd/wb_data only move on an actual write, so forwarding sees stable values otherwise.
  always_comb begin
    w_state_nxt   = r_state;
    w_to_cnt_nxt  = r_to_cnt;
    w_ld_rd_nxt   = r_ld_rd;
    w_ld_f3_nxt   = r_ld_f3;
    w_ld_lo_nxt   = r_ld_lo;
    w_wb_we_nxt   = 1'b0;
    w_wb_rd_nxt   = r_wb_rd;
    w_wb_data_nxt = r_wb_data;
    w_bus_err_nxt = r_bus_err;
    w_retire_nxt  = r_retire;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_src == WB_LOAD) begin
            w_ld_rd_nxt  = in_rd;
            w_ld_f3_nxt  = in_funct3;
            w_ld_lo_nxt  = in_addr_lo;
            w_to_cnt_nxt = '0;
            w_state_nxt  = WAIT_LOAD;
          end else begin
            w_retire_nxt = r_retire + CNT_W'(1);
            if (w_src != WB_NONE && in_rd != 5'd0) begin
              w_wb_we_nxt   = 1'b1;
              w_wb_rd_nxt   = in_rd;
              w_wb_data_nxt = (w_src == WB_PC4) ? in_pc4 : in_alu;
            end
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          w_retire_nxt = r_retire + CNT_W'(1);
          w_state_nxt  = IDLE;
          if (r_ld_rd != 5'd0) begin
            w_wb_we_nxt   = 1'b1;
            w_wb_rd_nxt   = r_ld_rd;
            w_wb_data_nxt = w_load_val;
          end
        end else if (r_to_cnt == TO_W'(LOAD_TIMEOUT - 1)) begin
          w_bus_err_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready     = (r_state == IDLE);
  assign load_pending = (r_state == WAIT_LOAD);
  assign load_rd      = (r_state == WAIT_LOAD) ? r_ld_rd : 5'd0;
  assign wb_we        = r_wb_we;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign bus_err      = r_bus_err;
  assign retire_cnt   = r_retire;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected register writes are queued at issue and matched when wb_we fires.
module tb_wb_stage;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_src;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu;
  logic [31:0] in_pc4;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        load_pending;
  logic [4:0]  load_rd;
  logic        bus_err;
  logic [31:0] retire_cnt;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  wb_stage #(.LOAD_TIMEOUT(4), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_wb_src    (in_wb_src),
    .in_funct3    (in_funct3),
    .in_addr_lo   (in_addr_lo),
    .in_alu       (in_alu),
    .in_pc4       (in_pc4),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .load_pending (load_pending),
    .load_rd      (load_rd),
    .bus_err      (bus_err),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and match any write against the scoreboard.
  task automatic tick(input logic exp_we);
    wr_t e;
    @(posedge clk);
    #1;
    chk("wb_we", 64'(wb_we), 64'(exp_we));
    if (wb_we === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wb_rd", 64'(wb_rd), 64'(e.rd));
      chk("wb_data", 64'(wb_data), 64'(e.data));
    end
  endtask

  task automatic issue(input logic [1:0] src, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [31:0] alu, input logic [31:0] pc4);
    in_valid   = 1'b1;
    in_wb_src  = src;
    in_rd      = rd;
    in_funct3  = f3;
    in_addr_lo = lo;
    in_alu     = alu;
    in_pc4     = pc4;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_wb_src = '0; in_funct3 = '0;
    in_addr_lo = '0; in_alu = '0; in_pc4 = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;

    // Reset: everything observable is zero.
    for (int i = 0; i < 2; i++) begin
      tick(1'b0);
      chk("rst_wb_rd", 64'(wb_rd), 64'd0);
      chk("rst_wb_data", 64'(wb_data), 64'd0);
      chk("rst_bus_err", 64'(bus_err), 64'd0);
      chk("rst_retire", 64'(retire_cnt), 64'd0);
      chk("rst_pending", 64'(load_pending), 64'd0);
      chk("rst_load_rd", 64'(load_rd), 64'd0);
    end
    rst = 1'b1;

    // ALU write, 1-cycle latency.
    issue(2'd0, 5'd5, 3'd0, 2'd0, 32'hDEADBEEF, 32'h0000_1004);
    exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    tick(1'b1);
    in_valid = 1'b0;
    chk("alu_retire", 64'(retire_cnt), 64'd1);
    tick(1'b0);
    chk("hold_data", 64'(wb_data), 64'hDEADBEEF);

    // PC4 write.
    issue(2'd2, 5'd1, 3'd0, 2'd0, 32'h1111_1111, 32'h0000_2004);
    exp_q.push_back('{rd: 5'd1, data: 32'h0000_2004});
    tick(1'b1);
    in_valid = 1'b0;
    chk("pc4_retire", 64'(retire_cnt), 64'd2);

    // Signed byte load, data three cycles after accept.
    issue(2'd1, 5'd3, 3'b000, 2'd2, 32'h0, 32'h0);
    tick(1'b0);
    in_valid = 1'b0;
    chk("lb_ready", 64'(in_ready), 64'd0);
    chk("lb_pending", 64'(load_pending), 64'd1);
    chk("lb_load_rd", 64'(load_rd), 64'd3);
    tick(1'b0);
    tick(1'b0);
    chk("lb_still_pending", 64'(load_pending), 64'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1280_3456;
    exp_q.push_back('{rd: 5'd3, data: 32'hFFFF_FF80});
    tick(1'b1);
    dmem_rvalid = 1'b0;
    chk("lb_retire", 64'(retire_cnt), 64'd3);
    chk("lb_done_pending", 64'(load_pending), 64'd0);
    tick(1'b0);

    // Unsigned half load, data on the earliest honoured cycle.
    issue(2'd1, 5'd7, 3'b101, 2'd2, 32'h0, 32'h0);
    tick(1'b0);
    in_valid = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_1234;
    exp_q.push_back('{rd: 5'd7, data: 32'h0000_BEEF});
    tick(1'b1);
    dmem_rvalid = 1'b0;
    chk("lhu_retire", 64'(retire_cnt), 64'd4);

    // Signed half load at offset 0 and full-word load.
    issue(2'd1, 5'd8, 3'b001, 2'd0, 32'h0, 32'h0);
    tick(1'b0);
    in_valid = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_9ABC;
    exp_q.push_back('{rd: 5'd8, data: 32'hFFFF_9ABC});
    tick(1'b1);
    issue(2'd1, 5'd9, 3'b010, 2'd0, 32'h0, 32'h0);
    dmem_rvalid = 1'b0;
    tick(1'b0);
    in_valid = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    exp_q.push_back('{rd: 5'd9, data: 32'hCAFE_F00D});
    tick(1'b1);
    dmem_rvalid = 1'b0;
    chk("lw_retire", 64'(retire_cnt), 64'd6);

    // rd=0 and WB_NONE retire without writing; rvalid in IDLE is ignored.
    issue(2'd0, 5'd0, 3'd0, 2'd0, 32'h5555_5555, 32'h0);
    tick(1'b0);
    issue(2'd3, 5'd9, 3'd0, 2'd0, 32'h6666_6666, 32'h0);
    tick(1'b0);
    in_valid = 1'b0;
    chk("none_retire", 64'(retire_cnt), 64'd8);
    chk("none_hold_rd", 64'(wb_rd), 64'd9);
    chk("none_hold_data", 64'(wb_data), 64'hCAFE_F00D);
    dmem_rvalid = 1'b1;
    tick(1'b0);
    dmem_rvalid = 1'b0;
    chk("idle_rvalid_retire", 64'(retire_cnt), 64'd8);

    // Load timeout after four cycles in WAIT_LOAD.
    issue(2'd1, 5'd4, 3'b010, 2'd0, 32'h0, 32'h0);
    tick(1'b0);
    in_valid = 1'b0;
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    chk("to_pending_before", 64'(load_pending), 64'd1);
    chk("to_err_before", 64'(bus_err), 64'd0);
    tick(1'b0);
    chk("to_bus_err", 64'(bus_err), 64'd1);
    chk("to_ready", 64'(in_ready), 64'd1);
    chk("to_pending", 64'(load_pending), 64'd0);
    chk("to_retire", 64'(retire_cnt), 64'd8);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    tick(1'b0);
    dmem_rvalid = 1'b0;
    chk("late_rvalid_retire", 64'(retire_cnt), 64'd8);

    // bus_err is sticky across later traffic.
    issue(2'd0, 5'd2, 3'd0, 2'd0, 32'h0000_0042, 32'h0);
    exp_q.push_back('{rd: 5'd2, data: 32'h0000_0042});
    tick(1'b1);
    in_valid = 1'b0;
    chk("sticky_err", 64'(bus_err), 64'd1);
    chk("post_to_retire", 64'(retire_cnt), 64'd9);

    // Reset mid-load drops the load.
    issue(2'd1, 5'd6, 3'b010, 2'd0, 32'h0, 32'h0);
    tick(1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick(1'b0);
    rst = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick(1'b0);
    dmem_rvalid = 1'b0;
    tick(1'b0);
    chk("mid_rst_pending", 64'(load_pending), 64'd0);
    chk("mid_rst_retire", 64'(retire_cnt), 64'd0);
    chk("mid_rst_err", 64'(bus_err), 64'd0);
    chk("mid_rst_data", 64'(wb_data), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the razor pipeline. Sits between the MEM stage and the register file.
- Accepts one retiring instruction at a time through a valid/ready handshake and waits for the data-memory response on loads.
- Aligns and sign- or zero-extends load data, then selects the writeback value.
- Drives a one-cycle write strobe, destination index and data into the register file. The same registered triple also feeds the forwarding and hazard logic.

Parameters:
- LOAD_TIMEOUT, 255, maximum cycles spent in WAIT_LOAD before the load is abandoned.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_rd  in  5  destination register index
- in_wb_src  in  2  writeback source: 0 ALU, 1 LOAD, 2 PC4, 3 NONE (store/branch)
- in_funct3  in  3  load size/sign (RV32I encoding)
- in_addr_lo  in  2  byte offset of load address
- in_alu  in  32  ALU result
- in_pc4  in  32  PC+4
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  raw 32-bit load word
- wb_we  out  1  register-file write enable
- wb_rd  out  5  register-file destination index
- wb_data  out  32  register-file write data
- load_pending  out  1  a load is in WAIT_LOAD
- load_rd  out  5  destination index of the pending load
- bus_err  out  1  sticky load-timeout flag
- retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=0 at posedge): state IDLE and all outputs 0, including bus_err, retire_cnt and timeout counter. Reset mid-load drops the load with no write.
- in_ready = (state==IDLE). An accept happens when in_valid && in_ready.
- States:
  - IDLE, with accept and wb_src != LOAD: next cycle wb_we = (in_rd != 0) and wb_data = selected value. Latency is exactly 1 cycle. Stay IDLE.
  - IDLE, with accept and wb_src == LOAD: latch rd, funct3 and addr_lo. Go to WAIT_LOAD and clear the timeout counter.
  - WAIT_LOAD, with dmem_rvalid: next cycle wb_we = (rd != 0) and wb_data = aligned load value. Go to IDLE.
  - WAIT_LOAD, without rvalid: increment the timeout counter. When the counter == LOAD_TIMEOUT-1 and rvalid is still low, set bus_err, go to IDLE, no write, no retire.
- dmem_rvalid is ignored in IDLE. Earliest honoured rvalid is the cycle after the load is accepted.
- wb_we is a single-cycle pulse. wb_rd and wb_data hold their last values while wb_we=0.
- wb_src NONE: wb_we=0 the cycle after accept, but the instruction still retires.
- rd==0: wb_we is held 0, but the instruction still retires.
- retire_cnt increments by 1 in the same cycle that the write slot is produced, whether or not wb_we is asserted. It wraps modulo 2^CNT_W.
- load_pending=1 and load_rd=latched rd while in WAIT_LOAD. Both are 0 otherwise.
- Load alignment uses byte = rdata[8*addr_lo +: 8] and half = rdata[16*addr_lo[1] +: 16]:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 010, 011, 110, 111: full word.
  - Misalignment is checked upstream and is not re-checked here.
- bus_err is cleared only by reset.

Decomposition:
- Package razor_pkg:
  - wb_src_e enum {WB_ALU, WB_LOAD, WB_PC4, WB_NONE}.
  - Load funct3 constants F3_LB/LH/LW/LBU/LHU.
  - wb_state_e {IDLE, WAIT_LOAD}.
- Sub-module load_align: combinational, inputs funct3/addr_lo/rdata, output 32-bit extended value. Instantiated once.

Test Plan:
- Reset and ALU write:
  - Stimulus: rst low 2 cycles, then accept ALU instruction rd=5, alu=0xDEADBEEF.
  - Required: all outputs 0 during reset. Next cycle wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, retire_cnt=1.
- Signed byte load:
  - Stimulus: LB rd=3, addr_lo=2; rvalid 3 cycles later with rdata=0x12_80_34_56.
  - Required: in_ready=0 and load_pending=1, load_rd=3 while waiting. Then wb_data=0xFFFFFF80 for one cycle.
- Unsigned half load:
  - Stimulus: LHU rd=7, addr_lo=2, rdata=0xBEEF1234.
  - Required: wb_data=0x0000BEEF.
- rd=0 and WB_NONE:
  - Stimulus: accept ALU instruction with rd=0, then a WB_NONE instruction.
  - Required: wb_we stays 0 both times; retire_cnt advances by 2.
- Load timeout:
  - Stimulus: LOAD_TIMEOUT=4, issue load, never assert rvalid.
  - Required: after 4 cycles in WAIT_LOAD, bus_err=1, state IDLE, in_ready=1, no write, retire_cnt unchanged. A late rvalid is ignored.
- Reset mid-load:
  - Stimulus: issue load, assert rst=0 while waiting, then rvalid arrives.
  - Required: no wb_we, load_pending=0, retire_cnt=0.
